// File: rtl/uart_tx_arbiter.sv
// Purpose : packet-granular round-robin share of the single UART TX FIFO write port.
// Latency : 1 cycle request-to-grant; bytes pass combinationally from owner to fifo_wdata.
// Backpr. : fifo_full drops the owner's req_ready and blocks fifo_wr in the same cycle.
//
// Optional feature macro: UART_ARB_TAG_EN -- when defined, each granted packet is
// preceded by one tag byte {4'hF, owner[3:0]} written from a TAG state.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid/_data/_last/_ready  N byte-stream requesters (byte i in req_data[8i+7:8i])
//   fifo_wr, fifo_wdata, fifo_full  UART TX FIFO write port
//   grant             registered one-hot owner, zero when idle
//   busy              high whenever the arbiter is not idle
//   timeout_evt       one-cycle pulse when an idle owner is forcibly released
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           fifo_wr,
  output logic [7:0]     fifo_wdata,
  input  logic           fifo_full,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           timeout_evt
);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE = 2'd0, TAG = 2'd1, XFER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd2} state_t;
`endif

  state_t       state, state_nxt;
  logic [3:0]   owner, owner_nxt;
  logic [3:0]   last_grant, last_grant_nxt;
  logic [N-1:0] grant_nxt;
  logic         busy_nxt;
  logic         evt_nxt;
  logic [15:0]  idle_cnt, idle_cnt_nxt;

  // Requester vectors widened to the 16-requester maximum so the 4-bit owner
  // index can address them for any legal N.
  logic [15:0]  valid_pad;
  logic [15:0]  last_pad;
  logic [127:0] data_pad;

  logic         found;
  logic [3:0]   winner;
  logic [4:0]   cand;

  logic         wr_c;
  logic [7:0]   wdata_c;

  assign valid_pad = 16'(req_valid);
  assign last_pad  = 16'(req_last);
  assign data_pad  = 128'(req_data);

  // Round-robin pick: first valid requester searching upward from last_grant+1,
  // wrapping at N.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    cand   = 5'd0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_grant} + 5'(k);
      if (cand >= 5'(N)) cand = cand - 5'(N);
      if (!found && valid_pad[cand[3:0]]) begin
        found  = 1'b1;
        winner = cand[3:0];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    grant_nxt      = grant;
    busy_nxt       = busy;
    evt_nxt        = 1'b0;
    idle_cnt_nxt   = idle_cnt;
    wr_c           = 1'b0;
    wdata_c        = 8'h00;

    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt    = winner;
          busy_nxt     = 1'b1;
          idle_cnt_nxt = '0;
          for (int i = 0; i < N; i++) grant_nxt[i] = (winner == 4'(i));
`ifdef UART_ARB_TAG_EN
          state_nxt = TAG;
`else
          state_nxt = XFER;
`endif
        end
      end

`ifdef UART_ARB_TAG_EN
      // Tag write waits on fifo_full indefinitely; the idle counter is frozen here.
      TAG: begin
        if (!fifo_full) begin
          wr_c      = 1'b1;
          wdata_c   = {4'hF, owner};
          state_nxt = XFER;
        end
      end
`endif

      XFER: begin
        if (valid_pad[owner] && !fifo_full) begin
          // A transfer always wins over a timeout reached in the same cycle.
          wr_c         = 1'b1;
          wdata_c      = data_pad[{owner, 3'b000} +: 8];
          idle_cnt_nxt = '0;
          if (last_pad[owner]) begin
            state_nxt      = IDLE;
            grant_nxt      = '0;
            busy_nxt       = 1'b0;
            last_grant_nxt = owner;
          end
        end else if ((TIMEOUT != 0) && (idle_cnt == 16'(TIMEOUT))) begin
          state_nxt      = IDLE;
          grant_nxt      = '0;
          busy_nxt       = 1'b0;
          last_grant_nxt = owner;
          evt_nxt        = 1'b1;
          idle_cnt_nxt   = '0;
        end else if (!fifo_full) begin
          // Owner has nothing to send while the FIFO has room: count it as idle.
          idle_cnt_nxt = idle_cnt + 16'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_grant  <= 4'(N - 1);
      grant       <= '0;
      busy        <= 1'b0;
      timeout_evt <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_grant  <= last_grant_nxt;
      grant       <= grant_nxt;
      busy        <= busy_nxt;
      timeout_evt <= evt_nxt;
      idle_cnt    <= idle_cnt_nxt;
    end
  end

  // Reset aborts at once: no write or handshake leaks out during the reset cycle.
  assign fifo_wr    = wr_c & ~rst;
  assign fifo_wdata = (wr_c && !rst) ? wdata_c : 8'h00;
  assign req_ready  = (state == XFER && !rst) ? (grant & {N{~fifo_full}}) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TAG_EN
  localparam int NREQ   = 8;
  localparam int TAGOFF = 1;
`else
  localparam int NREQ   = 4;
  localparam int TAGOFF = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_wr;
  logic [7:0]        fifo_wdata;
  logic              fifo_full;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              timeout_evt;

  uart_tx_arbiter #(.N(NREQ), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .busy       (busy),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  logic [8:0]      pq [NREQ][$];   // per-requester producer queue {last, data}
  logic [7:0]      exp_q [$];      // expected FIFO byte order
  logic [NREQ-1:0] expg_q [$];     // expected grant order

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int evt_cyc = 0;
  int evt_count = 0;
  int idle_run = 0;
  int e0;
  logic            chk_gap = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;
  logic [NREQ-1:0] acc_q = '0;
  logic            rst_v = 1'b1;
  logic            full_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    rst       = rst_v;
    fifo_full = full_v;
    for (int i = 0; i < NREQ; i++) begin
      if (pq[i].size() > 0) begin
        h = pq[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i]        = h[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic [7:0]      e;
    logic [NREQ-1:0] g;
    acc_q = req_valid & req_ready;
    if (fifo_wr) begin
      chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wdata", 32'(fifo_wdata), 32'(e));
      end
      last_wr_cyc = cyc;
    end else begin
      chk("wdata_zero_no_wr", 32'(fifo_wdata), 32'd0);
    end
    chk("no_wr_when_full", 32'(fifo_wr & fifo_full), 32'd0);
    chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    chk("busy_vs_grant", 32'(busy), 32'(grant != '0));
    if (grant != '0 && prev_grant == '0) begin
      chk("grant_expected", 32'(expg_q.size() > 0), 32'd1);
      if (expg_q.size() > 0) begin
        g = expg_q.pop_front();
        chk("grant_order", 32'(grant), 32'(g));
      end
      if (chk_gap) chk("idle_gap", 32'(idle_run), 32'd1);
    end
    idle_run   = (grant == '0) ? idle_run + 1 : 0;
    prev_grant = grant;
    if (timeout_evt) begin
      evt_count++;
      evt_cyc = cyc;
    end
  endtask

  // One clock: apply queued inputs just after the edge, sample at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++)
      if (acc_q[i]) void'(pq[i].pop_front());
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic prod(input int r, input logic [7:0] d, input logic last);
    pq[r].push_back({last, d});
  endtask

  task automatic exptag(input int r);
`ifdef UART_ARB_TAG_EN
    exp_q.push_back({4'hF, 4'(r)});
`else
    if (r < 0) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    tick();
    tick();
    rst_v = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || grant != '0) && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    chk({tag, "_grants"}, 32'(expg_q.size()), 32'd0);
  endtask

  initial begin
    rst_v  = 1'b1;
    full_v = 1'b0;
    drive();

    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_evt", 32'(timeout_evt), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wr", 32'(fifo_wr), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);

    // Single 3-byte packet from requester 0
    prod(0, 8'h41, 1'b0); prod(0, 8'h42, 1'b0); prod(0, 8'h43, 1'b1);
    exptag(0); exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    expg_q.push_back(NREQ'(1));
    tick();
    chk("t1_req_cycle_grant", 32'(grant), 32'd0);
    chk("t1_idle_ready", 32'(req_ready), 32'd0);
    tick();
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (TAGOFF) tick();
    chk("t1_b0", {fifo_wr, fifo_wdata}, 32'h141);
    tick();
    chk("t1_b1", {fifo_wr, fifo_wdata}, 32'h142);
    tick();
    chk("t1_b2", {fifo_wr, fifo_wdata}, 32'h143);
    tick();
    chk("t1_end_grant", 32'(grant), 32'd0);
    chk("t1_end_busy", 32'(busy), 32'd0);
    chk("t1_end_wr", 32'(fifo_wr), 32'd0);

    // All four requesters with 1-byte packets: order 0,1,2,3,0
    do_reset();
    prod(0, 8'hA0, 1'b1); prod(0, 8'hB0, 1'b1);
    prod(1, 8'hA1, 1'b1); prod(2, 8'hA2, 1'b1); prod(3, 8'hA3, 1'b1);
    for (int r = 0; r < 4; r++) begin
      exptag(r);
      exp_q.push_back(8'hA0 + 8'(r));
      expg_q.push_back(NREQ'(1) << r);
    end
    exptag(0); exp_q.push_back(8'hB0); expg_q.push_back(NREQ'(1));
    tick();
    tick();
    chk("t2_first_grant", 32'(grant), 32'd1);
    chk_gap = 1'b1;
    drain("t2_drain");
    chk_gap = 1'b0;

    // Requester 2 stalled by fifo_full for 10 cycles mid-packet
    do_reset();
    for (int b = 0; b < 4; b++) prod(2, 8'h20 + 8'(b), b == 3);
    exptag(2);
    for (int b = 0; b < 4; b++) exp_q.push_back(8'h20 + 8'(b));
    expg_q.push_back(NREQ'(4));
    e0 = evt_count;
    tick();
    tick();
    chk("t3_grant", 32'(grant), 32'd4);
    repeat (TAGOFF) tick();
    chk("t3_b0", {fifo_wr, fifo_wdata}, 32'h120);
    tick();
    chk("t3_b1", {fifo_wr, fifo_wdata}, 32'h121);
    full_v = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_ready_full", 32'(req_ready[2]), 32'd0);
      chk("t3_wr_full", 32'(fifo_wr), 32'd0);
    end
    full_v = 1'b0;
    tick();
    chk("t3_b2", {fifo_wr, fifo_wdata}, 32'h122);
    tick();
    chk("t3_b3", {fifo_wr, fifo_wdata}, 32'h123);
    tick();
    chk("t3_end_grant", 32'(grant), 32'd0);
    chk("t3_no_evt", 32'(evt_count - e0), 32'd0);

    // Owner 1 goes silent after one byte; requester 2 is pending
    do_reset();
    prod(1, 8'h51, 1'b0);
    prod(2, 8'h61, 1'b1);
    exptag(1); exp_q.push_back(8'h51);
    exptag(2); exp_q.push_back(8'h61);
    expg_q.push_back(NREQ'(2));
    expg_q.push_back(NREQ'(4));
    e0 = evt_count;
    begin
      int k = 0;
      while (evt_count == e0 && k < 60) begin
        tick();
        k++;
      end
    end
    chk("t4_evt_seen", 32'(evt_count - e0), 32'd1);
    // Transfer in cycle t clears the counter; it reads 8 in cycle t+9, so the
    // release edge ends t+9 and the registered pulse appears in t+10.
    chk("t4_evt_delay", 32'(evt_cyc - last_wr_cyc), 32'd10);
    chk("t4_evt_grant", 32'(grant), 32'd0);
    chk("t4_evt_busy", 32'(busy), 32'd0);
    tick();
    chk("t4_next_grant", 32'(grant), 32'd4);
    drain("t4_drain");
    chk("t4_evt_once", 32'(evt_count - e0), 32'd1);

    // Reset for one cycle mid-packet from requester 3
    for (int b = 0; b < 4; b++) prod(3, 8'h71 + 8'(b), b == 3);
    exptag(3); exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    expg_q.push_back(NREQ'(8));
    tick();
    tick();
    chk("t5_grant", 32'(grant), 32'd8);
    repeat (TAGOFF) tick();
    chk("t5_b0", {fifo_wr, fifo_wdata}, 32'h171);
    tick();
    chk("t5_b1", {fifo_wr, fifo_wdata}, 32'h172);
    rst_v = 1'b1;
    tick();
    chk("t5_rst_wr", 32'(fifo_wr), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    rst_v = 1'b0;
    pq[3].delete();
    prod(0, 8'h80, 1'b1);
    prod(3, 8'h83, 1'b1);
    exptag(0); exp_q.push_back(8'h80);
    exptag(3); exp_q.push_back(8'h83);
    expg_q.push_back(NREQ'(1));
    expg_q.push_back(NREQ'(8));
    tick();
    chk("t5_post_grant", 32'(grant), 32'd0);
    chk("t5_post_busy", 32'(busy), 32'd0);
    chk("t5_post_wr", 32'(fifo_wr), 32'd0);
    tick();
    chk("t5_first_after_rst", 32'(grant), 32'd1);
    drain("t5_drain");

`ifdef UART_ARB_TAG_EN
    // Tag byte ahead of requester 5's packet
    do_reset();
    prod(5, 8'h10, 1'b0);
    prod(5, 8'h11, 1'b1);
    exptag(5); exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    expg_q.push_back(NREQ'(32));
    tick();
    tick();
    chk("t6_grant", 32'(grant), 32'h20);
    chk("t6_tag", {fifo_wr, fifo_wdata}, 32'h1F5);
    chk("t6_tag_ready", 32'(req_ready), 32'd0);
    tick();
    chk("t6_b0", {fifo_wr, fifo_wdata}, 32'h110);
    tick();
    chk("t6_b1", {fifo_wr, fifo_wdata}, 32'h111);
    drain("t6_drain");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
